// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS IF stage with PC, handshaked imem read port, IF/ID register and redirect/stall handling
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branchControlInput,
  input  logic [31:0] pcBranchInput,
  input  logic        jumpInput,
  input  logic [31:0] pcJumpInput,
  input  logic        ifFlushInput,
  input  logic        stallInput,
  output logic        imemRequestOutput,
  output logic [31:0] imemAddressOutput,
  input  logic        imemReadyInput,
  input  logic [31:0] imemDataInput,
  output logic [31:0] instructionOutput,
  output logic [31:0] pc4Output,
  output logic        instructionValidOutput,
  output logic [31:0] pcOutput
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, hbuf, hbuf_n, hpc4, hpc4_n, pend, pend_n;
  logic [31:0] target, pc_plus4, load_instr, load_pc4, instr_n, pc4_n;
  logic redir, load, bubble, flush, take, valid_n;
  assign redir = jumpInput | branchControlInput;
  assign target = (jumpInput ? pcJumpInput : pcBranchInput) & ~32'h3;
  assign pc_plus4 = pc + 32'd4;
  assign imemRequestOutput = (state == FETCH) || (state == DRAIN);
  assign imemAddressOutput = pc;
  assign pcOutput = pc;
  assign flush = ifFlushInput && !stallInput;
  assign take = load && !flush;
  assign instr_n = take ? load_instr : (bubble || flush) ? NOP : instructionOutput;
  assign pc4_n = take ? load_pc4 : pc4Output;
  assign valid_n = take || (!(bubble || flush) && instructionValidOutput);
  always_comb begin
    state_n = state;
    pc_n = pc;
    hbuf_n = hbuf;
    hpc4_n = hpc4;
    pend_n = pend;
    load = 1'b0;
    bubble = 1'b0;
    load_instr = imemDataInput;
    load_pc4 = pc_plus4;
    case (state)
      IDLE: state_n = FETCH;
      FETCH:
        if (stallInput) begin
          if (imemReadyInput) begin
            hbuf_n = imemDataInput;
            hpc4_n = pc_plus4;
            pc_n = pc_plus4;
            state_n = HOLD;
          end
        end else if (imemReadyInput) begin
          pc_n = redir ? target : pc_plus4;
          load = !redir;
          bubble = redir;
        end else begin
          bubble = 1'b1;
          pend_n = redir ? target : pend;
          state_n = redir ? DRAIN : FETCH;
        end
      HOLD:
        if (!stallInput) begin
          state_n = FETCH;
          pc_n = redir ? target : pc;
          load = !redir;
          bubble = redir;
          load_instr = hbuf;
          load_pc4 = hpc4;
        end
      DRAIN: begin
        bubble = 1'b1;
        if (imemReadyInput) begin
          pc_n = (redir && !stallInput) ? target : pend;
          state_n = FETCH;
        end else if (redir && !stallInput) begin
          pend_n = target;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      hbuf <= '0;
      hpc4 <= '0;
      pend <= '0;
      instructionOutput <= NOP;
      pc4Output <= '0;
      instructionValidOutput <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      hbuf <= hbuf_n;
      hpc4 <= hpc4_n;
      pend <= pend_n;
      instructionOutput <= instr_n;
      pc4Output <= pc4_n;
      instructionValidOutput <= valid_n;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table-driven directed checks of the instruction fetch stage
module tb_instruction_fetch;
  logic clk, reset, br, j, fl, st, rdy, req, valid;
  logic [31:0] pcb, pcj, data, addr, instr, pc4, pc;
  int total = 0;
  int passed = 0;
  typedef struct {
    logic rn, br;
    logic [31:0] pcb;
    logic j;
    logic [31:0] pcj;
    logic fl, st, rdy;
    logic [31:0] d;
    logic req;
    logic [31:0] addr, instr, pc4;
    logic valid;
    logic [31:0] pc;
  } vec_t;
  vec_t vecs[$];
  instruction_fetch dut (
    .clk(clk), .reset(reset),
    .branchControlInput(br), .pcBranchInput(pcb),
    .jumpInput(j), .pcJumpInput(pcj),
    .ifFlushInput(fl), .stallInput(st),
    .imemRequestOutput(req), .imemAddressOutput(addr),
    .imemReadyInput(rdy), .imemDataInput(data),
    .instructionOutput(instr), .pc4Output(pc4),
    .instructionValidOutput(valid), .pcOutput(pc)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  function automatic vec_t v(input logic rn, br, input logic [31:0] pcb, input logic j,
                             input logic [31:0] pcj, input logic fl, st, rdy, input logic [31:0] d,
                             input logic req, input logic [31:0] addr, instr, pc4,
                             input logic valid, input logic [31:0] pc);
    vec_t r;
    r.rn = rn; r.br = br; r.pcb = pcb; r.j = j; r.pcj = pcj; r.fl = fl; r.st = st;
    r.rdy = rdy; r.d = d; r.req = req; r.addr = addr; r.instr = instr; r.pc4 = pc4;
    r.valid = valid; r.pc = pc;
    return r;
  endfunction
  task automatic chk(input string name, input int row, input logic [31:0] act, exp);
    total++;
    if (act !== exp) $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    else passed++;
  endtask
  task automatic run(input int row, input vec_t x);
    reset = x.rn; br = x.br; pcb = x.pcb; j = x.j; pcj = x.pcj;
    fl = x.fl; st = x.st; rdy = x.rdy; data = x.d;
    #1;
    chk("req", row, {31'b0, req}, {31'b0, x.req});
    chk("addr", row, addr, x.addr);
    @(posedge clk);
    #1;
    chk("instr", row, instr, x.instr);
    chk("pc4", row, pc4, x.pc4);
    chk("valid", row, {31'b0, valid}, {31'b0, x.valid});
    chk("pc", row, pc, x.pc);
  endtask
  initial begin
    reset = 0; br = 0; pcb = 0; j = 0; pcj = 0; fl = 0; st = 0; rdy = 0; data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", -1, {31'b0, req}, 32'h0);
    chk("rst_addr", -1, addr, 32'h0);
    chk("rst_instr", -1, instr, 32'h0);
    chk("rst_pc4", -1, pc4, 32'h0);
    chk("rst_valid", -1, {31'b0, valid}, 32'h0);
    chk("rst_pc", -1, pc, 32'h0);
    vecs.push_back(v(1,0,0,0,0,0,0,0,0,             0,0,             0,0,1'b0,0));
    vecs.push_back(v(1,0,0,0,0,0,0,1,0,             1,0,             0,4,1,4));
    vecs.push_back(v(1,0,0,0,0,0,0,1,4,             1,4,             4,8,1,8));
    vecs.push_back(v(1,0,0,0,0,0,0,1,8,             1,8,             8,12,1,12));
    vecs.push_back(v(1,0,0,0,0,0,0,0,0,             1,12,            0,12,0,12));
    vecs.push_back(v(1,0,0,0,0,0,0,0,0,             1,12,            0,12,0,12));
    vecs.push_back(v(1,0,0,0,0,0,0,1,12,            1,12,            12,16,1,16));
    vecs.push_back(v(1,0,0,0,0,0,1,1,'h10,          1,'h10,          12,16,1,'h14));
    vecs.push_back(v(1,0,0,0,0,0,1,0,0,             0,'h14,          12,16,1,'h14));
    vecs.push_back(v(1,1,'h80,0,0,1,1,0,0,          0,'h14,          12,16,1,'h14));
    vecs.push_back(v(1,0,0,0,0,0,0,0,0,             0,'h14,          'h10,'h14,1,'h14));
    vecs.push_back(v(1,0,0,0,0,0,0,1,'h14,          1,'h14,          'h14,'h18,1,'h18));
    vecs.push_back(v(1,0,0,0,0,0,0,1,'h18,          1,'h18,          'h18,'h1C,1,'h1C));
    vecs.push_back(v(1,0,0,0,0,0,0,1,'h1C,          1,'h1C,          'h1C,'h20,1,'h20));
    vecs.push_back(v(1,1,'h40,0,0,0,0,0,0,          1,'h20,          0,'h20,0,'h20));
    vecs.push_back(v(1,0,0,0,0,0,0,0,0,             1,'h20,          0,'h20,0,'h20));
    vecs.push_back(v(1,0,0,0,0,0,0,1,'h20,          1,'h20,          0,'h20,0,'h40));
    vecs.push_back(v(1,0,0,0,0,0,0,1,'h40,          1,'h40,          'h40,'h44,1,'h44));
    vecs.push_back(v(1,1,'h200,1,'h103,0,0,1,'h44,  1,'h44,          0,'h44,0,'h100));
    vecs.push_back(v(1,0,0,0,0,0,0,1,'h100,         1,'h100,         'h100,'h104,1,'h104));
    vecs.push_back(v(1,0,0,0,0,1,0,1,'h104,         1,'h104,         0,'h104,0,'h108));
    vecs.push_back(v(1,0,0,0,0,0,0,1,'h108,         1,'h108,         'h108,'h10C,1,'h10C));
    vecs.push_back(v(1,0,0,1,'hFFFF_FFFC,0,0,0,0,   1,'h10C,         0,'h10C,0,'h10C));
    vecs.push_back(v(1,0,0,0,0,0,0,1,'h10C,         1,'h10C,         0,'h10C,0,'hFFFF_FFFC));
    vecs.push_back(v(1,0,0,0,0,0,0,1,'hFFFF_FFFC,   1,'hFFFF_FFFC,   'hFFFF_FFFC,0,1,0));
    vecs.push_back(v(1,0,0,0,0,0,0,1,0,             1,0,             0,4,1,4));
    vecs.push_back(v(1,1,'h60,0,0,0,0,0,0,          1,4,             0,4,0,4));
    vecs.push_back(v(0,0,0,0,0,0,0,0,0,             1,4,             0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0,0,0,0,             0,0,             0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0,0,1,0,             1,0,             0,4,1,4));
    foreach (vecs[i]) run(i, vecs[i]);
    run(100, v(1,0,0,0,0,0,1,1,'h4,                 1,4,             0,4,1,8));
    run(101, v(1,1,'h300,0,0,0,0,0,0,               0,8,             0,4,0,'h300));
    run(102, v(1,1,'h500,0,0,0,0,0,0,               1,'h300,         0,4,0,'h300));
    run(103, v(1,0,0,1,'h600,0,0,0,0,               1,'h300,         0,4,0,'h300));
    run(104, v(1,0,0,0,0,0,0,1,'hDEAD,              1,'h300,         0,4,0,'h600));
    run(105, v(1,0,0,0,0,0,0,1,'h600,               1,'h600,         'h600,'h604,1,'h604));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
